// File: rtl/bit_reverse_buffer_pkg.sv
// Shared types and helpers for the ping-pong bit-reverse reorder buffer.
// Frame length is a module parameter; the values here are defaults and hard limits.
package bit_reverse_pkg;

  localparam int MAX_LOG_N     = 10;
  localparam int DEFAULT_LOG_N = 3;
  localparam int N             = 1 << DEFAULT_LOG_N;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  // Reverses the low log_n bits of value; bits above log_n come back as zero.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] value,
                                                  input int log_n);
    logic [MAX_LOG_N-1:0] v;
    logic [MAX_LOG_N-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < MAX_LOG_N; i++) begin
      if (i < log_n) begin
        r = {r[MAX_LOG_N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/brb_bank.sv
// One frame of coefficient storage: synchronous write port, combinational read port.
module brb_bank #(
  parameter int W     = 17,
  parameter int LOG_N = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [LOG_N-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [LOG_N-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  localparam int NF = 1 << LOG_N;

  logic [W-1:0] mem_q [NF];

  // NOTE: storage is deliberately not reset; the bank state machine in the
  // top decides which entries are valid, so stale contents are never observed.
  // State updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bit_reverse_buffer.sv
// Streaming ping-pong reorder buffer: frames arrive in natural order and
// leave in bit-reversed (mode=0) or natural (mode=1) order.
module bit_reverse_buffer
  import bit_reverse_pkg::*;
#(
  parameter int W     = 17,
  parameter int LOG_N = DEFAULT_LOG_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         frame_err
);

  localparam int               NF       = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(NF - 1);

  bank_state_e      bank_st_q [2];
  bank_state_e      bank_st_d [2];
  logic [1:0]       bank_mode_q, bank_mode_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [LOG_N-1:0] wcnt_q, wcnt_d;
  logic [LOG_N-1:0] rcnt_q, rcnt_d;
  logic             ready_en_q;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;

  logic             in_fire;
  logic             out_free;
  logic             rd_en;
  logic [LOG_N-1:0] raddr_rev;
  logic [LOG_N-1:0] raddr;
  logic [1:0]       bank_we;
  logic [W-1:0]     rdata [2];

  // ready_en_q keeps in_ready low while reset is asserted and releases it one edge later.
  assign in_ready = ready_en_q &&
                    (bank_st_q[wbank_q] == BANK_EMPTY || bank_st_q[wbank_q] == BANK_FILLING);
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;
  assign rd_en    = out_free &&
                    (bank_st_q[rbank_q] == BANK_FULL || bank_st_q[rbank_q] == BANK_DRAINING);

  assign raddr_rev = LOG_N'(bitrev(MAX_LOG_N'(rcnt_q), LOG_N));
  assign raddr     = bank_mode_q[rbank_q] ? rcnt_q : raddr_rev;

  assign bank_we[0] = in_fire && !wbank_q;
  assign bank_we[1] = in_fire &&  wbank_q;

  brb_bank #(.W(W), .LOG_N(LOG_N)) u_bank0 (
    .clk     (clk),
    .we_i    (bank_we[0]),
    .waddr_i (wcnt_q),
    .wdata_i (in_data),
    .raddr_i (raddr),
    .rdata_o (rdata[0])
  );

  brb_bank #(.W(W), .LOG_N(LOG_N)) u_bank1 (
    .clk     (clk),
    .we_i    (bank_we[1]),
    .waddr_i (wcnt_q),
    .wdata_i (in_data),
    .raddr_i (raddr),
    .rdata_o (rdata[1])
  );

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned (no latches); combinational logic uses blocking assignments.
  // The write side only touches a bank that is EMPTY/FILLING and the read side
  // only one that is FULL/DRAINING, so both may update bank_st_d in one cycle.
  always_comb begin
    bank_st_d   = bank_st_q;
    bank_mode_d = bank_mode_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_err_d = in_fire && (in_last != (wcnt_q == LAST_IDX));

    if (in_fire) begin
      wcnt_d             = wcnt_q + LOG_N'(1);
      bank_st_d[wbank_q] = BANK_FILLING;
      if (wcnt_q == '0) begin
        bank_mode_d[wbank_q] = mode;
      end
      if (wcnt_q == LAST_IDX) begin
        bank_st_d[wbank_q] = BANK_FULL;
        wbank_d            = !wbank_q;
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (rd_en) begin
      out_valid_d        = 1'b1;
      out_data_d         = rdata[rbank_q];
      out_last_d         = (rcnt_q == LAST_IDX);
      rcnt_d             = rcnt_q + LOG_N'(1);
      bank_st_d[rbank_q] = BANK_DRAINING;
      if (rcnt_q == LAST_IDX) begin
        bank_st_d[rbank_q] = BANK_EMPTY;
        rbank_d            = !rbank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      bank_mode_q  <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      ready_en_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bank_st_q    <= bank_st_d;
      bank_mode_q  <= bank_mode_d;
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      ready_en_q   <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/bit_reverse_buffer.md
Name: bit_reverse_buffer

Overview:
- Streaming reorder buffer for NTT data.
- Accepts coefficient frames of N = 2^LOG_N samples in natural order and emits each frame in bit-reversed (or natural, per mode) order.
- Ping-pong banks let one frame fill while the previous one drains.
- Sits between the coefficient loader and the NTT butterfly pipeline; replaces fixed combinational permutation wiring with a parametrised, back-pressured stream.

Parameters:
- W, 17, coefficient width in bits
- LOG_N, 3, log2 of frame length; N = 2^LOG_N, legal range 1..10

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = bit-reversed output, 1 = natural order; sampled on first accepted sample of a frame
- in_valid  input  1  input sample valid
- in_ready  output  1  buffer can accept a sample
- in_data  input  W  input coefficient
- in_last  input  1  marks the final sample of a frame
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts the sample
- out_data  output  W  output coefficient
- out_last  output  1  final sample of an output frame
- frame_err  output  1  one-cycle pulse: in_last position mismatch

Behaviour:
- Reset (async assert, sync release): in_ready=0 during reset and 1 the first cycle after. out_valid=0, out_data=0, out_last=0, frame_err=0. Both banks EMPTY. Write and read counters 0. Write bank=0, read bank=0.
- Handshakes: input transfers when in_valid&&in_ready; output transfers when out_valid&&out_ready.
  - Once out_valid=1, out_data and out_last stay stable until transfer.
  - in_ready does not depend combinationally on in_valid.
- Bank states: EMPTY -> FILLING (first write) -> FULL (N-th write) -> DRAINING (read side takes the bank) -> EMPTY (N-th read transfer).
- Bank mode bit: each bank stores the mode bit captured at its first write.
- Write side:
  - Sample k of a frame goes to address k of the write bank; wcnt increments modulo N.
  - On wcnt==N-1 transfer the bank becomes FULL and the write bank pointer toggles.
  - in_ready = 1 iff the current write bank is EMPTY or FILLING.
- in_last check:
  - If in_last=1 on a transfer with wcnt!=N-1, or in_last=0 with wcnt==N-1, frame_err pulses the next cycle.
  - Frame boundaries are still defined by wcnt only; in_last never truncates or extends a frame.
- Read side:
  - When the read bank is FULL and the output register is empty or transferring, the bank becomes DRAINING.
  - Read address = bitrev(rcnt, LOG_N) if the bank mode bit is 0, else rcnt.
  - Output register loads mem[bank][addr]; out_last=1 when rcnt==N-1.
  - After the N-th read the bank goes EMPTY and the read pointer toggles.
- Latency: first out_valid one cycle after the N-th input transfer when the read side is idle. Throughput is 1 sample/cycle sustained with out_ready=1 (back-to-back frames, no bubbles).
- Simultaneous events:
  - A bank freed by its last read transfer is seen as EMPTY by the write side in the next cycle, not the same cycle.
  - A write and a read in the same cycle to different banks are always legal.
  - Write and read banks never alias while DRAINING.
- Both banks FULL/DRAINING: in_ready=0 until one bank is released.
- Reset mid-frame: all partial and full frames are discarded; memory contents are don't-care, no clear required.
- LOG_N=1: bitrev is the identity. Reverse and natural modes give the same order.

Decomposition:
- Package bit_reverse_pkg:
  - bank state enum (EMPTY, FILLING, FULL, DRAINING)
  - function bitrev(value, LOG_N)
  - localparam N = 1<<LOG_N
- One natural sub-module, brb_bank: W x N register-array storage with one synchronous write port and one combinational read port, instantiated twice.
- Counters, bank FSMs and the output register stay in the top.

Test Plan:
- LOG_N=3, mode=0, inputs 0..7 with in_last on 7 -> out 0,4,2,6,1,5,3,7; out_last on 7; first out_valid one cycle after input 7 accepted.
- Two back-to-back frames (0..7, 8..15), out_ready=1 -> out 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no gap; in_ready never drops.
- out_ready=0 for 20 cycles after frame 1 while driving frames 2 and 3 -> in_ready falls after frame 2 fills. With out_ready held low, out_data holds 0. Releasing out_ready drains frame 1 then 2 in order, with no loss.
- Frame 1 mode=0, frame 2 mode=1 (mode toggled mid-frame 2 is ignored) -> frame 2 out 8,9,...,15 in natural order.
- in_last asserted on sample 5 -> frame_err pulses once; frame still completes at sample 7 with correct reversed output.
- rst_n pulsed low after 4 samples of a frame -> out_valid=0 immediately; after release a fresh frame 0..7 yields 0,4,2,6,1,5,3,7.
